// File: rtl/mem_save_arbiter_if.sv
// Bus bundle between the requesters/memory bank and mem_save_arbiter.
// Carries the requester handshake, the read-response path and the
// save-style memory cell bank wiring (save strobes, value bus, cell outputs).
// Optional feature macro: MEM_ARB_LOCK_EN adds the per-requester req_lock bus.
interface mem_save_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic [DEPTH-1:0]       mem_save;
    logic [WIDTH-1:0]       mem_value;
    logic [DEPTH*WIDTH-1:0] mem_out;
`ifdef MEM_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif

    // The master side is the environment: requesters plus the cell bank,
    // which is why it also drives mem_out back to the arbiter.
`ifdef MEM_ARB_LOCK_EN
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock, mem_out,
        input  req_ready, rsp_valid, rsp_data, mem_save, mem_value
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock, mem_out,
        output req_ready, rsp_valid, rsp_data, mem_save, mem_value
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_out,
        input  req_ready, rsp_valid, rsp_data, mem_save, mem_value
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_out,
        output req_ready, rsp_valid, rsp_data, mem_save, mem_value
    );
`endif
endinterface

// File: rtl/mem_save_arbiter.sv
// mem_save_arbiter: shares one bank of DEPTH save-style cells among NREQ
// requesters. Round-robin grant, one access per cycle, power-on clear of
// every cell, read latency of one cycle with write-to-read forwarding.
// Optional feature macro: MEM_ARB_LOCK_EN (burst lock via req_lock).
module mem_save_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    mem_save_arbiter_if.slave arb
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      clrCnt_q;
    logic [PW-1:0]      rrPtr_q;
    logic [DEPTH-1:0]   memSave_q;
    logic [WIDTH-1:0]   memValue_q;
    logic [NREQ-1:0]    rspValid_q;
    logic [WIDTH-1:0]   rspData_q;
`ifdef MEM_ARB_LOCK_EN
    logic               lockHeld_q;
`endif

    logic               grantFound;
    logic [PW-1:0]      grantIdx;
    logic [NREQ-1:0]    grantVec;
    logic               grantWe;
    logic [AW-1:0]      grantAddr;
    logic [WIDTH-1:0]   grantData;
    logic [WIDTH-1:0]   cellWord;
    logic               bypassHit;

    // Requester slot 'offset' positions after 'base', wrapping at NREQ.
    function automatic logic [PW-1:0] slotAt(input logic [PW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Round-robin search: first valid requester at or after rrPtr_q.
    // Only valids are looked at, so the grant never feeds back on itself.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grantFound && arb.req_valid[slotAt(rrPtr_q, k)]) begin
                    grantFound = 1'b1;
                    grantIdx   = slotAt(rrPtr_q, k);
                end
            end
        end
    end

    assign grantVec  = grantFound ? (NREQ'(1) << grantIdx) : '0;
    assign grantWe   = arb.req_we[grantIdx];
    assign grantAddr = arb.req_addr[grantIdx*AW +: AW];
    assign grantData = arb.req_wdata[grantIdx*WIDTH +: WIDTH];
    assign cellWord  = arb.mem_out[grantAddr*WIDTH +: WIDTH];

    // A write pulse currently on the bus has not reached the cell yet, so a
    // read of the same word this cycle must take the data off the value bus.
    assign bypassHit = memSave_q[grantAddr];

    // While clearing, the save strobe walks across the bank decoded from the
    // clear counter; afterwards it is the registered write pulse.
    assign arb.mem_save  = (state_q == CLEAR) ? (DEPTH'(1) << clrCnt_q) : memSave_q;
    assign arb.mem_value = memValue_q;
    assign arb.req_ready = grantVec;
    assign arb.rsp_valid = rspValid_q;
    assign arb.rsp_data  = rspData_q;

    // Controller FSM: clear sequence, then arbitration with registered
    // write pulses and read responses; reset restarts the clear and drops
    // anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clrCnt_q   <= '0;
            rrPtr_q    <= '0;
            memSave_q  <= '0;
            memValue_q <= '0;
            rspValid_q <= '0;
            rspData_q  <= '0;
`ifdef MEM_ARB_LOCK_EN
            lockHeld_q <= 1'b0;
`endif
        end else begin
            memSave_q  <= '0;
            memValue_q <= '0;
            rspValid_q <= '0;
            rspData_q  <= '0;
            case (state_q)
                CLEAR: begin
                    clrCnt_q <= clrCnt_q + 1'b1;
                    if (clrCnt_q == AW'(DEPTH - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (grantFound) begin
                        if (grantWe) begin
                            memSave_q  <= DEPTH'(1) << grantAddr;
                            memValue_q <= grantData;
                        end else begin
                            rspValid_q <= grantVec;
                            rspData_q  <= bypassHit ? memValue_q : cellWord;
                        end
`ifdef MEM_ARB_LOCK_EN
                        if (arb.req_lock[grantIdx]) begin
                            rrPtr_q    <= grantIdx;
                            lockHeld_q <= 1'b1;
                        end else begin
                            rrPtr_q    <= slotAt(grantIdx, 1);
                            lockHeld_q <= 1'b0;
                        end
                    end else if (lockHeld_q) begin
                        rrPtr_q    <= slotAt(rrPtr_q, 1);
                        lockHeld_q <= 1'b0;
                    end
`else
                        rrPtr_q <= slotAt(grantIdx, 1);
                    end
`endif
                end
                default: begin
                    state_q  <= CLEAR;
                    clrCnt_q <= '0;
                end
            endcase
        end
    end
endmodule
